tx_buf_serializer: RTL and testbench
====================================

// Module: tx_buf_serializer
// PURPOSE
//  Reads a completed 13-byte CAN transmit buffer over its byte-address read port and emits the frame
//  as an unstuffed, MSB-first bit stream: SOF, arbitration, control, data and optional CRC.
//  It feeds the bit-stuffing/bit-timing engine through a valid/ack bit handshake.
//  Buffer layout: byte0 = frame info (b7 FF ext, b6 RTR, b3:0 DLC); bytes 1-2 = std ID; bytes 1-4 = ext ID.
// PARAMETERS
//  ADR_W     4  buffer address width
//  DATA_MAX  8  max data bytes sent; DLC values above it are still transmitted verbatim in the DLC field
// PORTS
//  clk        in   1      single clock, all logic on rising edge
//  rst        in   1      asynchronous, active-high reset
//  tx_req     in   1      start request; sampled only in IDLE
//  abort      in   1      cancel the frame in progress
//  buf_adr    out  ADR_W  buffer byte address
//  buf_data   in   8      buffer read data; combinational function of buf_adr, same cycle
//  bit_ack    in   1      bit engine consumed bit_out this cycle
//  bit_valid  out  1      bit_out holds a frame bit
//  bit_out    out  1      current frame bit, 0 = dominant
//  bit_last   out  1      bit_out is the final bit of the frame
//  busy       out  1      a frame is in progress, INFO..SHIFT
//  done       out  1      one-cycle pulse after the last bit is acked
// BEHAVIOUR
//  Reset: all outputs 0 (buf_adr=0). FSM enters IDLE. Any frame in progress is discarded, no done.
//  FSM: IDLE -(tx_req & !abort)-> INFO -> SHIFT -(ack of bit_last)-> DONE -> IDLE.
//  INFO (1 cycle): buf_adr=0; latch FF, RTR, DLC. First bit (SOF=0) is valid the cycle after INFO,
//   i.e. tx_req at cycle N gives bit_valid at N+2.
//  Bit order, standard frame: SOF, ID[10:0] (byte1[7:0], byte2[7:5]), RTR, IDE=0, r0=0, DLC[3:0],
//   then data bytes 3.. MSB first.
//  Bit order, extended frame: SOF, ID[28:18], SRR=1, IDE=1, ID[17:0], RTR, r1=0, r0=0, DLC[3:0],
//   then data bytes 5.. MSB first. ID[28:0] = byte1..byte4[7:3].
//  Data byte count = RTR ? 0 : min(DLC, DATA_MAX).
//  Header length is 19 bits (std) or 39 bits (ext), plus 8*bytes data bits, plus 15 CRC bits if enabled.
//  Handshake: bit_out/bit_last are stable while bit_valid & !bit_ack.
//   Ack in cycle k: next bit presented in k+1, no bubble, even across byte and field boundaries.
//   Prefetch: buf_adr points at the next needed byte before the current byte's last bit is acked;
//   each byte is loaded exactly once.
//  bit_last is high only alongside the final bit. bit_valid drops the cycle after that bit's ack.
//   done pulses in that same cycle, then IDLE.
//  abort while busy: FSM returns to IDLE next cycle, bit_valid/busy low, no done. Abort has priority
//   over a coincident bit_ack. abort in IDLE is ignored.
//  tx_req while busy or in DONE is ignored and not queued.
//  buf_adr never exceeds 12. Bit counters saturate and cannot wrap.
// CONFIGURATION
//  CAN_TX_CRC_EN defined: CRC-15 (poly 15'h4599, init 0) is computed over SOF..last data bit and
//   appended MSB first; bit_last marks CRC bit 0.
//  CAN_TX_CRC_EN undefined: no CRC logic; bit_last marks the last data bit, or the DLC[0] bit when there
//   are no data bytes.
// STRUCTURE
//  can_tx_defs.vh: FSM state encodings, CRC_POLY, byte offsets ADR_INFO=0, STD_DATA0=3, EXT_DATA0=5,
//   header lengths 19/39.
//  Sub-module can_crc15: serial CRC register with clk/rst/clear/en/bit_in/crc[14:0]. Instantiated only
//   under CAN_TX_CRC_EN. The receiver reuses it.
// TESTING
//  Std frame, ID=0x123, DLC=2, data A5 5A, bit_ack tied 1 -> 35 data-path bits, no gaps.
//   bit_valid at N+2; done 1 cycle after last ack; +15 CRC bits matching the bench model with CRC_EN.
//  Ext frame, ID=0x1ABCDEF0, RTR=1, DLC=8 -> 39 header bits, zero data bits; SRR=1 and IDE=1 at
//   bit positions 12 and 13.
//  DLC=15 with RTR=0 -> DLC field 1111 sent; exactly 8 data bytes read (buf_adr 3..10); buf_adr never >12.
//  Random bit_ack stalls of 0-5 cycles -> bit_out/bit_last stable during stalls; stream identical to
//   the no-stall run.
//  abort asserted with bit_ack on bit 20 -> bit_valid low next cycle, no done. A new tx_req then gives
//   a full correct frame.
//  rst pulsed mid data field -> all outputs 0 asynchronously; tx_req during busy ignored; next request
//   starts cleanly from SOF.

Source files
------------

// File: rtl/tx_buf_serializer_pkg.sv
// Shared types and constants for the CAN transmit-buffer serializer and its CRC helper.
package tx_buf_serializer_pkg;

    typedef enum logic [1:0] {StIdle, StInfo, StShift, StDone} state_t;

    typedef enum logic [2:0] {SrcZero, SrcOne, SrcByte, SrcRtr, SrcDlc} bit_src_t;

    typedef struct packed {
        bit_src_t   src;
        logic [2:0] idx;
        logic       load;
    } bit_sel_t;

    localparam logic [14:0] CRC_POLY    = 15'h4599;
    localparam int unsigned ADR_INFO    = 0;
    localparam int unsigned ADR_LAST    = 12;
    localparam int unsigned STD_HDR_LEN = 19;
    localparam int unsigned EXT_HDR_LEN = 39;

    // Source of header bit p; load marks the first bit taken from a fresh buffer byte.
    function automatic bit_sel_t hdr_bit(input logic ext, input logic [5:0] p);
        bit_sel_t s;
        s = '{src: SrcZero, idx: 3'd0, load: 1'b0};
        if (p >= 6'd1 && p <= 6'd8) begin
            s = '{src: SrcByte, idx: 3'(6'd8 - p), load: (p == 6'd1)};
        end else if (p >= 6'd9 && p <= 6'd11) begin
            s = '{src: SrcByte, idx: 3'(6'd16 - p), load: (p == 6'd9)};
        end else if (!ext) begin
            if (p == 6'd12) s.src = SrcRtr;
            else if (p >= 6'd15 && p <= 6'd18) s = '{src: SrcDlc, idx: 3'(6'd18 - p), load: 1'b0};
        end else begin
            if (p == 6'd12 || p == 6'd13) s.src = SrcOne;
            else if (p >= 6'd14 && p <= 6'd18) s = '{src: SrcByte, idx: 3'(6'd18 - p), load: 1'b0};
            else if (p >= 6'd19 && p <= 6'd26)
                s = '{src: SrcByte, idx: 3'(6'd26 - p), load: (p == 6'd19)};
            else if (p >= 6'd27 && p <= 6'd31)
                s = '{src: SrcByte, idx: 3'(6'd34 - p), load: (p == 6'd27)};
            else if (p == 6'd32) s.src = SrcRtr;
            else if (p >= 6'd35 && p <= 6'd38) s = '{src: SrcDlc, idx: 3'(6'd38 - p), load: 1'b0};
        end
        return s;
    endfunction

endpackage

// File: rtl/can_crc15.sv
// Serial CAN CRC-15 register (poly 0x4599, init 0); present only when CAN_TX_CRC_EN is defined.
`ifdef CAN_TX_CRC_EN
module can_crc15
    import tx_buf_serializer_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        clear,
    input  logic        en,
    input  logic        bit_in,
    output logic [14:0] crc
);
    logic fb;
    assign fb = bit_in ^ crc[14];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            crc <= '0;
        end else if (clear) begin
            crc <= '0;
        end else if (en) begin
            crc <= {crc[13:0], 1'b0} ^ (fb ? CRC_POLY : 15'h0);
        end
    end
endmodule
`endif

// File: rtl/tx_buf_serializer.sv
// Streams a CAN transmit buffer as unstuffed MSB-first frame bits over a valid/ack handshake.
// Define CAN_TX_CRC_EN to append the CRC-15 field.
module tx_buf_serializer
    import tx_buf_serializer_pkg::*;
#(
    parameter int unsigned ADR_W    = 4,
    parameter int unsigned DATA_MAX = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             tx_req,
    input  logic             abort,
    output logic [ADR_W-1:0] buf_adr,
    input  logic [7:0]       buf_data,
    input  logic             bit_ack,
    output logic             bit_valid,
    output logic             bit_out,
    output logic             bit_last,
    output logic             busy,
    output logic             done
);
`ifdef CAN_TX_CRC_EN
    localparam int unsigned CRC_LEN = 15;
`else
    localparam int unsigned CRC_LEN = 0;
`endif
    localparam int unsigned POS_W = $clog2(EXT_HDR_LEN + 8 * DATA_MAX + CRC_LEN + 1);
    typedef logic [POS_W-1:0] pos_t;

    state_t     state;
    logic       ff_q, rtr_q, bit_q;
    logic [3:0] dlc_q;
    logic [7:0] byte_q;
    pos_t       pos_q;

    pos_t       n_bytes, hdr_len, data_end, total_len, pos_nxt;
    logic [2:0] rel_bit;
    bit_sel_t   sel;
    logic [7:0] view;
    logic       nxt_bit;

    always_comb begin
        n_bytes   = rtr_q ? '0 : ((32'(dlc_q) > DATA_MAX) ? pos_t'(DATA_MAX) : pos_t'(dlc_q));
        hdr_len   = ff_q ? pos_t'(EXT_HDR_LEN) : pos_t'(STD_HDR_LEN);
        data_end  = hdr_len + (n_bytes << 3);
        total_len = data_end + pos_t'(CRC_LEN);
        pos_nxt   = (pos_q == '1) ? pos_q : pos_q + pos_t'(1);
        rel_bit   = 3'(pos_nxt - hdr_len);
        sel       = hdr_bit(ff_q, 6'(pos_nxt));
        if (pos_nxt >= hdr_len) begin
            sel.src  = SrcByte;
            sel.idx  = 3'd7 - rel_bit;
            sel.load = (rel_bit == 3'd0) && (pos_nxt < data_end);
        end
        // A fresh byte is used straight off the read port in the cycle it is latched.
        view = sel.load ? buf_data : byte_q;
        case (sel.src)
            SrcOne:  nxt_bit = 1'b1;
            SrcByte: nxt_bit = view[sel.idx];
            SrcRtr:  nxt_bit = rtr_q;
            SrcDlc:  nxt_bit = dlc_q[sel.idx[1:0]];
            default: nxt_bit = 1'b0;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= StIdle;
            ff_q      <= 1'b0;
            rtr_q     <= 1'b0;
            dlc_q     <= 4'd0;
            byte_q    <= 8'd0;
            pos_q     <= '0;
            bit_q     <= 1'b0;
            buf_adr   <= '0;
            bit_valid <= 1'b0;
            bit_last  <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
        end else begin
            case (state)
                StIdle: begin
                    done    <= 1'b0;
                    buf_adr <= ADR_W'(ADR_INFO);
                    if (tx_req && !abort) begin
                        state <= StInfo;
                        busy  <= 1'b1;
                    end
                end
                StInfo: begin
                    if (abort) begin
                        state <= StIdle;
                        busy  <= 1'b0;
                    end else begin
                        ff_q      <= buf_data[7];
                        rtr_q     <= buf_data[6];
                        dlc_q     <= buf_data[3:0];
                        pos_q     <= '0;
                        bit_q     <= 1'b0;
                        bit_valid <= 1'b1;
                        bit_last  <= 1'b0;
                        buf_adr   <= ADR_W'(ADR_INFO + 1);
                        state     <= StShift;
                    end
                end
                StShift: begin
                    if (abort || (bit_ack && bit_last)) begin
                        state     <= abort ? StIdle : StDone;
                        done      <= !abort;
                        bit_valid <= 1'b0;
                        bit_last  <= 1'b0;
                        bit_q     <= 1'b0;
                        busy      <= 1'b0;
                        buf_adr   <= '0;
                    end else if (bit_ack) begin
                        pos_q    <= pos_nxt;
                        bit_q    <= nxt_bit;
                        bit_last <= (pos_nxt == total_len - pos_t'(1));
                        if (sel.load) begin
                            byte_q <= buf_data;
                            if (buf_adr != ADR_W'(ADR_LAST)) buf_adr <= buf_adr + ADR_W'(1);
                        end
                    end
                end
                StDone: begin
                    done  <= 1'b0;
                    state <= StIdle;
                end
                default: state <= StIdle;
            endcase
        end
    end

`ifdef CAN_TX_CRC_EN
    logic [14:0] crc;
    logic        in_crc_q;
    logic [3:0]  crc_idx_q;

    can_crc15 u_crc (
        .clk    (clk),
        .rst    (rst),
        .clear  (state == StInfo),
        .en     (state == StShift && bit_ack && !abort && !in_crc_q),
        .bit_in (bit_q),
        .crc    (crc)
    );

    // CRC bits come straight from the frozen CRC register once the data field is done.
    assign bit_out = in_crc_q ? crc[crc_idx_q] : bit_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            in_crc_q  <= 1'b0;
            crc_idx_q <= 4'd0;
        end else if (state != StShift || abort || (bit_ack && bit_last)) begin
            in_crc_q  <= 1'b0;
            crc_idx_q <= 4'd0;
        end else if (bit_ack && pos_nxt >= data_end) begin
            in_crc_q  <= 1'b1;
            crc_idx_q <= !in_crc_q ? 4'd14 : (crc_idx_q != 4'd0 ? crc_idx_q - 4'd1 : 4'd0);
        end
    end
`else
    assign bit_out = bit_q;
`endif

endmodule

// File: tb/tb_tx_buf_serializer.sv
// Self-checking bench for tx_buf_serializer against a field-level frame model (honours CAN_TX_CRC_EN).
module tb_tx_buf_serializer;
`ifdef CAN_TX_CRC_EN
    localparam int CRC_LEN = 15;
`else
    localparam int CRC_LEN = 0;
`endif

    logic       clk = 1'b0;
    logic       rst, tx_req, abort, bit_ack;
    logic [3:0] buf_adr;
    logic [7:0] buf_data;
    logic       bit_valid, bit_out, bit_last, busy, done;

    logic [7:0] mem [16];
    bit         exp_bits[$];
    int         n_checks = 0;
    int         n_pass = 0;
    int         done_cnt = 0;

    assign buf_data = mem[buf_adr];

    always #5 clk = ~clk;
    always @(negedge clk) if (done) done_cnt++;

    tx_buf_serializer #(.ADR_W(4), .DATA_MAX(8)) dut (
        .clk       (clk),
        .rst       (rst),
        .tx_req    (tx_req),
        .abort     (abort),
        .buf_adr   (buf_adr),
        .buf_data  (buf_data),
        .bit_ack   (bit_ack),
        .bit_valid (bit_valid),
        .bit_out   (bit_out),
        .bit_last  (bit_last),
        .busy      (busy),
        .done      (done)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic set_buf(input bit ff, input bit rtr, input logic [3:0] dlc,
                           input logic [28:0] id);
        for (int i = 0; i < 16; i++) mem[i] = (i < 13) ? 8'($urandom) : 8'h00;
        mem[0] = {ff, rtr, mem[0][5:4], dlc};
        if (ff) begin
            mem[1] = id[28:21];
            mem[2] = id[20:13];
            mem[3] = id[12:5];
            mem[4] = {id[4:0], mem[4][2:0]};
        end else begin
            mem[1] = id[10:3];
            mem[2] = {id[2:0], mem[2][4:0]};
        end
    endtask

    // Frame model built field by field from the buffer contents.
    task automatic build_model();
        logic [10:0] sid;
        logic [28:0] eid;
        logic [14:0] crc;
        bit          ff, rtr, fb;
        int          dlc, nb, first;
        ff  = mem[0][7];
        rtr = mem[0][6];
        dlc = int'(mem[0][3:0]);
        exp_bits.delete();
        exp_bits.push_back(1'b0);
        if (!ff) begin
            sid = {mem[1], mem[2][7:5]};
            for (int i = 10; i >= 0; i--) exp_bits.push_back(sid[i]);
            first = 3;
        end else begin
            eid = {mem[1], mem[2], mem[3], mem[4][7:3]};
            for (int i = 28; i >= 18; i--) exp_bits.push_back(eid[i]);
            exp_bits.push_back(1'b1);
            exp_bits.push_back(1'b1);
            for (int i = 17; i >= 0; i--) exp_bits.push_back(eid[i]);
            first = 5;
        end
        exp_bits.push_back(rtr);
        exp_bits.push_back(1'b0);
        exp_bits.push_back(1'b0);
        for (int i = 3; i >= 0; i--) exp_bits.push_back(mem[0][i]);
        nb = rtr ? 0 : (dlc > 8 ? 8 : dlc);
        for (int b = 0; b < nb; b++)
            for (int i = 7; i >= 0; i--) exp_bits.push_back(mem[first + b][i]);
        crc = 15'h0;
        foreach (exp_bits[k]) begin
            fb  = exp_bits[k] ^ crc[14];
            crc = {crc[13:0], 1'b0} ^ (fb ? 15'h4599 : 15'h0);
        end
        if (CRC_LEN != 0)
            for (int i = 14; i >= 0; i--) exp_bits.push_back(crc[i]);
    endtask

    // Runs one frame; abort_pos/rst_pos/req_pos select the disturbance (-1 = none).
    task automatic run_frame(input string tag, input int stall_max, input int abort_pos,
                             input int rst_pos, input int req_pos, input int exp_len);
        int idx, w, max_adr, dn0;
        bit ended, last;
        build_model();
        dn0     = done_cnt;
        idx     = 0;
        max_adr = 0;
        ended   = 1'b0;
        tx_req  = 1'b1;
        @(posedge clk); #1;
        tx_req = 1'b0;
        check({tag, "_info"}, {busy, bit_valid}, 2'b10);
        @(posedge clk); #1;
        check({tag, "_first_valid"}, {bit_valid, busy}, 2'b11);
        while (!ended) begin
            if (int'(buf_adr) > max_adr) max_adr = int'(buf_adr);
            last = (idx == exp_bits.size() - 1);
            check($sformatf("%s_bit%0d", tag, idx), {bit_valid, bit_out, bit_last},
                  {1'b1, exp_bits[idx], last});
            if (bit_valid !== 1'b1) begin
                ended = 1'b1;
            end else if (idx == rst_pos) begin
                rst = 1'b1;
                #2;
                check({tag, "_async_rst"}, {bit_valid, bit_out, bit_last, busy, done, buf_adr}, 0);
                @(posedge clk); #1;
                rst = 1'b0;
                check({tag, "_rst_no_done"}, done_cnt, dn0);
                ended = 1'b1;
            end else if (idx == abort_pos) begin
                bit_ack = 1'b1;
                abort   = 1'b1;
                @(posedge clk); #1;
                bit_ack = 1'b0;
                abort   = 1'b0;
                check({tag, "_abort"}, {bit_valid, busy, done}, 3'b000);
                @(posedge clk); #1;
                check({tag, "_abort_no_done"}, {done_cnt, busy}, {dn0, 1'b0});
                ended = 1'b1;
            end else begin
                w = (stall_max > 0) ? int'($urandom_range(0, stall_max)) : 0;
                tx_req = (idx == req_pos);
                for (int s = 0; s < w; s++) begin
                    bit_ack = 1'b0;
                    @(posedge clk); #1;
                    tx_req = 1'b0;
                    check($sformatf("%s_stall%0d", tag, idx), {bit_valid, bit_out, bit_last},
                          {1'b1, exp_bits[idx], last});
                end
                bit_ack = 1'b1;
                @(posedge clk); #1;
                bit_ack = 1'b0;
                tx_req  = 1'b0;
                idx++;
                if (last) begin
                    ended = 1'b1;
                    check({tag, "_done"}, {bit_valid, done, busy}, 3'b010);
                    check({tag, "_done_cnt"}, done_cnt, dn0);
                    if (exp_len >= 0) check({tag, "_len"}, idx, exp_len);
                    tx_req = 1'b1;
                    @(posedge clk); #1;
                    tx_req = 1'b0;
                    check({tag, "_idle"}, {done, busy, bit_valid}, 3'b000);
                    @(posedge clk); #1;
                    check({tag, "_no_queue"}, {busy, done_cnt}, {1'b0, dn0 + 1});
                end
            end
        end
        check({tag, "_adr_max"}, max_adr > 12, 0);
    endtask

    initial begin
        rst     = 1'b1;
        tx_req  = 1'b0;
        abort   = 1'b0;
        bit_ack = 1'b0;
        for (int i = 0; i < 16; i++) mem[i] = 8'h00;
        @(posedge clk); @(posedge clk); #1;
        check("reset", {bit_valid, bit_out, bit_last, busy, done, buf_adr}, 0);
        rst = 1'b0;
        @(posedge clk); #1;

        tx_req = 1'b1;
        abort  = 1'b1;
        @(posedge clk); #1;
        tx_req = 1'b0;
        abort  = 1'b0;
        check("req_with_abort", {busy, bit_valid}, 2'b00);

        set_buf(1'b0, 1'b0, 4'd2, 29'h123);
        mem[3] = 8'hA5;
        mem[4] = 8'h5A;
        run_frame("std123", 0, -1, -1, -1, 35 + CRC_LEN);
        run_frame("std123_stall", 5, -1, -1, -1, 35 + CRC_LEN);

        set_buf(1'b1, 1'b1, 4'd8, 29'h1ABCDEF0);
        run_frame("ext_rtr", 0, -1, -1, -1, 39 + CRC_LEN);

        set_buf(1'b0, 1'b0, 4'd15, 29'($urandom));
        run_frame("dlc15", 2, -1, -1, 30, 19 + 64 + CRC_LEN);

        set_buf(1'b1, 1'b0, 4'd8, 29'($urandom));
        run_frame("ext_dlc8", 1, -1, -1, -1, 39 + 64 + CRC_LEN);

        set_buf(1'b0, 1'b0, 4'd4, 29'($urandom));
        run_frame("abort20", 0, 20, -1, -1, -1);
        run_frame("after_abort", 2, -1, -1, -1, 19 + 32 + CRC_LEN);

        set_buf(1'b0, 1'b0, 4'd4, 29'($urandom));
        run_frame("rst25", 1, -1, 25, 22, -1);
        run_frame("after_rst", 0, -1, -1, -1, 19 + 32 + CRC_LEN);

        for (int f = 0; f < 6; f++) begin
            set_buf(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                    4'($urandom_range(0, 15)), 29'($urandom));
            run_frame($sformatf("rand%0d", f), 3, -1, -1, -1, -1);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
